// File: rtl/fpall_pkg.sv
// Shared types and default latencies for the FP datapath and its issue sequencer.
package fpall_pkg;

  typedef enum logic [1:0] {
    FP_ADD  = 2'b00,
    FP_MUL  = 2'b01,
    FP_SQRT = 2'b10,
    FP_DIV  = 2'b11
  } fp_op_e;

  typedef enum logic {
    FP_FMT_FP32 = 1'b0,
    FP_FMT_BF16 = 1'b1
  } fp_fmt_e;

  localparam int FPALL_LAT_ADD  = 2;
  localparam int FPALL_LAT_MUL  = 3;
  localparam int FPALL_LAT_SQRT = 6;
  localparam int FPALL_LAT_DIV  = 6;
  localparam int FPALL_TAG_W    = 4;

  typedef struct packed {
    fp_op_e                 op;
    fp_fmt_e                fmt;
    logic [31:0]            x;
    logic [31:0]            y;
    logic [FPALL_TAG_W-1:0] tag;
  } fpall_req_t;

  typedef struct packed {
    logic [FPALL_TAG_W-1:0] tag;
    logic [31:0]            r;
  } fpall_rsp_t;

  function automatic int lat_of(input fp_op_e op);
    case (op)
      FP_ADD:  return FPALL_LAT_ADD;
      FP_MUL:  return FPALL_LAT_MUL;
      FP_SQRT: return FPALL_LAT_SQRT;
      default: return FPALL_LAT_DIV;
    endcase
  endfunction

endpackage

// File: rtl/fpall_rsp_fifo.sv
// Small synchronous response FIFO; head entry is read straight from the register array.
module fpall_rsp_fifo
  import fpall_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type ELEM_T = fpall_rsp_t
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  ELEM_T                      din,
  input  logic                       pop,
  output ELEM_T                      dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ELEM_T         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push & ~do_pop)      count <= count + CW'(1);
      else if (do_pop & ~do_push) count <= count - CW'(1);
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = ~empty;

  // Upstream credit accounting must make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/fpall_issue_seq.sv
// Issue sequencer for the free-running FP datapath: reserves a unique capture edge
// per op, tracks its tag alongside, and returns {tag, R} through a credited FIFO.
module fpall_issue_seq
  import fpall_pkg::*;
#(
  parameter int LAT_ADD    = FPALL_LAT_ADD,
  parameter int LAT_MUL    = FPALL_LAT_MUL,
  parameter int LAT_SQRT   = FPALL_LAT_SQRT,
  parameter int LAT_DIV    = FPALL_LAT_DIV,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = FPALL_TAG_W
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic             in_fmt,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic [1:0]       dut_opcode,
  output logic             dut_fmt,
  output logic [31:0]      dut_x,
  output logic [31:0]      dut_y,
  input  logic [31:0]      dut_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int M01     = (LAT_ADD  > LAT_MUL) ? LAT_ADD  : LAT_MUL;
  localparam int M23     = (LAT_SQRT > LAT_DIV) ? LAT_SQRT : LAT_DIV;
  localparam int MAX_LAT = (M01 > M23) ? M01 : M23;
  localparam int LW      = $clog2(MAX_LAT + 1);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      r;
  } rsp_t;

  // Bit k-1 of resv / entry k-1 of tagp stands for "capture due k edges from now".
  logic [MAX_LAT:0]             resv, resv_nxt;
  logic [MAX_LAT:0][TAG_W-1:0]  tagp, tagp_nxt;
  logic [LW-1:0]                lat;
  logic [CW-1:0]                inflight, fifo_cnt;
  logic                         accept, capture, credit_ok;
  rsp_t                         wr_rsp, rd_rsp;

  always_comb begin
    case (fp_op_e'(in_opcode))
      FP_ADD:  lat = LW'(LAT_ADD);
      FP_MUL:  lat = LW'(LAT_MUL);
      FP_SQRT: lat = LW'(LAT_SQRT);
      default: lat = LW'(LAT_DIV);
    endcase
  end

  // Credits count both in-flight ops and queued results so a capture always has room.
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_cnt}) < (CW + 1)'(FIFO_DEPTH);
  assign in_ready  = rst_n & ~resv[lat] & credit_ok;
  assign accept    = in_valid & in_ready;
  assign capture   = resv[0];

  always_comb begin
    resv_nxt = {1'b0, resv[MAX_LAT:1]};
    tagp_nxt = {TAG_W'(0), tagp[MAX_LAT:1]};
    if (accept) begin
      resv_nxt[lat - LW'(1)] = 1'b1;
      tagp_nxt[lat - LW'(1)] = in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv       <= '0;
      tagp       <= '0;
      inflight   <= '0;
      dut_opcode <= '0;
      dut_fmt    <= 1'b0;
      dut_x      <= '0;
      dut_y      <= '0;
    end else begin
      resv <= resv_nxt;
      tagp <= tagp_nxt;
      case ({accept, capture})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
      if (accept) begin
        dut_opcode <= in_opcode;
        dut_fmt    <= in_fmt;
        dut_x      <= in_x;
        dut_y      <= in_y;
      end
    end
  end

  assign wr_rsp = '{tag: tagp[0], r: dut_r};

  fpall_rsp_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ELEM_T (rsp_t)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .din   (wr_rsp),
    .pop   (out_ready),
    .dout  (rd_rsp),
    .valid (out_valid),
    .count (fifo_cnt)
  );

  assign out_r   = rd_rsp.r;
  assign out_tag = rd_rsp.tag;
  assign busy    = (inflight != '0) | out_valid;

endmodule
